alu_8bit: RTL and testbench
===========================

Name: alu_8bit

Overview:
- Registered 8-bit arithmetic/logic unit with 16 operations selected by a 4-bit opcode.
- Produces a 16-bit result, wide enough for a full product or a quotient/remainder pair, plus a carry/status flag.
- Sits as a datapath leaf. The combinational ALU core is followed by one output register stage on the single system clock.

Parameters:
DATA_W, 8, operand width; result width is 2*DATA_W. Only 8 is required to be verified.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
operation  input  4  opcode select
A  input  8  operand A, unsigned
B  input  8  operand B, unsigned
result  output  16  registered result
carry_flag  output  1  registered carry/borrow/status flag

Behaviour:
- Reset: while rst_n=0, result=16'h0000 and carry_flag=0, immediately and independent of clk. Deassertion is synchronised by the user. First capture occurs at the first rising edge with rst_n=1.
- Latency: operation, A and B are sampled at a rising edge. result and carry_flag update at that same edge. Both hold until the next edge. One result per cycle, no handshake, no enable.
- Inputs may change every cycle; only values present at the edge matter.
- All operands are unsigned. Unless stated otherwise, result[15:8]=8'h00 and carry_flag=0.
- Opcode table (result / carry_flag):
  - 0000 ADD: result[8:0]=A+B / carry=result[8].
  - 0001 SUB: result[7:0]=A-B mod 256 / carry=1 iff A<B (borrow).
  - 0010 MUL: result=A*B full 16 bits / carry=1 iff product>255.
  - 0011 DIV: result[7:0]=A/B, result[15:8]=A%B / carry=0.
    - B=0: result[7:0]=8'hFF, result[15:8]=A, carry=1 (divide error).
  - 0100 AND: A&B.
  - 0101 OR: A|B.
  - 0110 XOR: A^B.
  - 0111 NOR: ~(A|B).
  - 1000 NAND: ~(A&B).
  - 1001 XNOR: ~(A^B).
  - 1010 SHL: result[7:0]={A[6:0],0} / carry=A[7].
  - 1011 SHR (logical): result[7:0]={0,A[7:1]} / carry=A[0].
  - 1100 ROL: result[7:0]={A[6:0],A[7]} / carry=A[7].
  - 1101 ROR: result[7:0]={A[0],A[7:1]} / carry=A[0].
  - 1110 CMP: result[0]=(A==B), result[1]=(A>B), result[2]=(A<B), all other bits 0 / carry=(A<B).
  - 1111 INC: result[8:0]=A+1 / carry=result[8] (1 only when A=8'hFF).
- B is ignored for opcodes 1010–1101 and 1111.
- Logic operations use only the low 8 bits of the result; result[15:8]=0.
- Reset asserted mid-stream: outputs clear immediately. The operation in flight is discarded, with no partial update on reset release.
- The opcode space is fully decoded, so there is no illegal opcode.

Test Plan:
- Reset: hold rst_n=0 with A=8'hFF, B=8'hFF, operation=0010 while toggling clk -> result=0, carry_flag=0. Assert rst_n low asynchronously between edges after valid output -> outputs clear without a clock edge.
- Arithmetic:
  - ADD A=8'hC8, B=8'h64 -> result=16'h012C, carry=1.
  - SUB A=8'h05, B=8'h0A -> result=16'h00FB, carry=1.
  - MUL A=8'hFF, B=8'hFF -> result=16'hFE01, carry=1.
- Division:
  - A=8'd200, B=8'd7 -> result=16'h041C (rem 4, quot 28), carry=0.
  - A=8'h37, B=0 -> result=16'h37FF, carry=1.
- Logic sweep with A=8'b1100_1010, B=8'b1010_0110 over opcodes 0100–1001 -> result low bytes 8'h82, 8'hEE, 8'h6C, 8'h11, 8'h7D, 8'h93; high byte 0, carry 0.
- Shift/rotate with A=8'b1000_0001:
  - SHL -> 8'h02, carry 1.
  - SHR -> 8'h40, carry 1.
  - ROL -> 8'h03, carry 1.
  - ROR -> 8'hC0, carry 1.
- CMP and INC:
  - CMP A=B=8'h10 -> result=16'h0001, carry 0.
  - CMP A=8'h01, B=8'h02 -> result=16'h0004, carry 1.
  - INC A=8'hFF -> result=16'h0100, carry 1.
- Back-to-back: all 16 opcodes in consecutive cycles with random A, B -> each output equals the reference model of the previous edge's inputs, one-cycle latency, no bubbles.

Source files
------------

// File: rtl/alu_8bit.sv
// Registered unsigned ALU: 16 opcodes, double-width result and a carry/status flag.
// The combinational core feeds one output register stage; reset clears it asynchronously.
module alu_8bit #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            operation,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  output logic [2*DATA_W-1:0]   result,
  output logic                  carry_flag
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_DIV  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_NOR  = 4'b0111,
    OP_NAND = 4'b1000,
    OP_XNOR = 4'b1001,
    OP_SHL  = 4'b1010,
    OP_SHR  = 4'b1011,
    OP_ROL  = 4'b1100,
    OP_ROR  = 4'b1101,
    OP_CMP  = 4'b1110,
    OP_INC  = 4'b1111
  } op_e;

  op_e                  op;
  logic [DATA_W:0]      sum;
  logic [DATA_W:0]      diff;
  logic [DATA_W:0]      incr;
  logic [2*DATA_W-1:0]  prod;
  logic [DATA_W-1:0]    quot;
  logic [DATA_W-1:0]    rem;
  logic [2*DATA_W-1:0]  result_d, result_q;
  logic                 carry_d, carry_q;

  assign op   = op_e'(operation);
  assign sum  = {1'b0, A} + {1'b0, B};
  // Borrow is the ninth bit of the extended subtraction
  assign diff = {1'b0, A} - {1'b0, B};
  assign incr = {1'b0, A} + {{DATA_W{1'b0}}, 1'b1};
  assign prod = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};

  always_comb begin
    quot = '1;
    rem  = A;
    if (B != '0) begin
      quot = A / B;
      rem  = A % B;
    end
  end

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    case (op)
      OP_ADD: begin
        result_d[DATA_W:0] = sum;
        carry_d            = sum[DATA_W];
      end
      OP_SUB: begin
        result_d[DATA_W-1:0] = diff[DATA_W-1:0];
        carry_d              = diff[DATA_W];
      end
      OP_MUL: begin
        result_d = prod;
        carry_d  = |prod[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        // Divide-by-zero reports all-ones quotient and A as remainder
        result_d = {rem, quot};
        carry_d  = (B == '0);
      end
      OP_AND:  result_d[DATA_W-1:0] = A & B;
      OP_OR:   result_d[DATA_W-1:0] = A | B;
      OP_XOR:  result_d[DATA_W-1:0] = A ^ B;
      OP_NOR:  result_d[DATA_W-1:0] = ~(A | B);
      OP_NAND: result_d[DATA_W-1:0] = ~(A & B);
      OP_XNOR: result_d[DATA_W-1:0] = ~(A ^ B);
      OP_SHL: begin
        result_d[DATA_W-1:0] = {A[DATA_W-2:0], 1'b0};
        carry_d              = A[DATA_W-1];
      end
      OP_SHR: begin
        result_d[DATA_W-1:0] = {1'b0, A[DATA_W-1:1]};
        carry_d              = A[0];
      end
      OP_ROL: begin
        result_d[DATA_W-1:0] = {A[DATA_W-2:0], A[DATA_W-1]};
        carry_d              = A[DATA_W-1];
      end
      OP_ROR: begin
        result_d[DATA_W-1:0] = {A[0], A[DATA_W-1:1]};
        carry_d              = A[0];
      end
      OP_CMP: begin
        result_d[0] = (A == B);
        result_d[1] = (A > B);
        result_d[2] = (A < B);
        carry_d     = (A < B);
      end
      OP_INC: begin
        result_d[DATA_W:0] = incr;
        carry_d            = incr[DATA_W];
      end
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result     = result_q;
  assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed self-checking bench for alu_8bit: reset, each opcode class, and a
// back-to-back sweep of all opcodes against an integer reference model.
module tb_alu_8bit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  operation;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] result;
  logic        carry_flag;

  int checks = 0;
  int errors = 0;

  alu_8bit #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .operation  (operation),
    .A          (A),
    .B          (B),
    .result     (result),
    .carry_flag (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] r_exp, input logic c_exp);
    checks++;
    assert (result === r_exp) else begin
      errors++;
      $error("FAIL %s result got %h exp %h", tag, result, r_exp);
    end
    checks++;
    assert (carry_flag === c_exp) else begin
      errors++;
      $error("FAIL %s carry got %b exp %b", tag, carry_flag, c_exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the capturing rising edge
  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    operation = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    int ia;
    int ib;
    int r;
    logic c;
    logic [15:0] rr;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    c  = 1'b0;
    case (op)
      4'd0:  begin r = ia + ib; c = (r > 255); end
      4'd1:  begin r = (ia - ib) & 255; c = (ia < ib); end
      4'd2:  begin r = ia * ib; c = (r > 255); end
      4'd3:  begin
        if (ib == 0) begin r = ia * 256 + 255; c = 1'b1; end
        else r = (ia % ib) * 256 + (ia / ib);
      end
      4'd4:  r = ia & ib;
      4'd5:  r = ia | ib;
      4'd6:  r = ia ^ ib;
      4'd7:  r = (~(ia | ib)) & 255;
      4'd8:  r = (~(ia & ib)) & 255;
      4'd9:  r = (~(ia ^ ib)) & 255;
      4'd10: begin r = (ia * 2) & 255; c = (ia >= 128); end
      4'd11: begin r = ia / 2; c = (ia % 2 == 1); end
      4'd12: begin r = ((ia * 2) & 255) + ia / 128; c = (ia >= 128); end
      4'd13: begin r = ia / 2 + (ia % 2) * 128; c = (ia % 2 == 1); end
      4'd14: begin r = (ia == ib) ? 1 : ((ia > ib) ? 2 : 4); c = (ia < ib); end
      default: begin r = ia + 1; c = (r > 255); end
    endcase
    rr = r[15:0];
    return {c, rr};
  endfunction

  initial begin
    logic [16:0] exp_v;
    rst_n     = 1'b0;
    operation = 4'b0010;
    A         = 8'hFF;
    B         = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 16'h0000, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", 16'h0000, 1'b0);

    apply(4'b0000, 8'hC8, 8'h64); check("add_carry", 16'h012C, 1'b1);
    apply(4'b0000, 8'h12, 8'h34); check("add_nocarry", 16'h0046, 1'b0);
    apply(4'b0001, 8'h05, 8'h0A); check("sub_borrow", 16'h00FB, 1'b1);
    apply(4'b0001, 8'h0A, 8'h0A); check("sub_zero", 16'h0000, 1'b0);
    apply(4'b0010, 8'hFF, 8'hFF); check("mul_max", 16'hFE01, 1'b1);
    apply(4'b0010, 8'h0F, 8'h11); check("mul_small", 16'h00FF, 1'b0);
    apply(4'b0011, 8'd200, 8'd7); check("div", 16'h041C, 1'b0);
    apply(4'b0011, 8'h37, 8'h00); check("div_zero", 16'h37FF, 1'b1);

    apply(4'b0100, 8'hCA, 8'hA6); check("and", 16'h0082, 1'b0);
    apply(4'b0101, 8'hCA, 8'hA6); check("or", 16'h00EE, 1'b0);
    apply(4'b0110, 8'hCA, 8'hA6); check("xor", 16'h006C, 1'b0);
    apply(4'b0111, 8'hCA, 8'hA6); check("nor", 16'h0011, 1'b0);
    apply(4'b1000, 8'hCA, 8'hA6); check("nand", 16'h007D, 1'b0);
    apply(4'b1001, 8'hCA, 8'hA6); check("xnor", 16'h0093, 1'b0);

    apply(4'b1010, 8'h81, 8'h5A); check("shl", 16'h0002, 1'b1);
    apply(4'b1011, 8'h81, 8'h5A); check("shr", 16'h0040, 1'b1);
    apply(4'b1100, 8'h81, 8'h5A); check("rol", 16'h0003, 1'b1);
    apply(4'b1101, 8'h81, 8'h5A); check("ror", 16'h00C0, 1'b1);
    apply(4'b1101, 8'h02, 8'hFF); check("ror_nocarry", 16'h0001, 1'b0);

    apply(4'b1110, 8'h10, 8'h10); check("cmp_eq", 16'h0001, 1'b0);
    apply(4'b1110, 8'h01, 8'h02); check("cmp_lt", 16'h0004, 1'b1);
    apply(4'b1110, 8'h90, 8'h02); check("cmp_gt", 16'h0002, 1'b0);
    apply(4'b1111, 8'hFF, 8'h00); check("inc_wrap", 16'h0100, 1'b1);
    apply(4'b1111, 8'h41, 8'hFF); check("inc", 16'h0042, 1'b0);

    // Asynchronous reset between edges, then release without a capture
    apply(4'b0010, 8'hFF, 8'hFF); check("pre_async", 16'hFE01, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_release", 16'h0000, 1'b0);

    for (int unsigned i = 0; i < 16; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [3:0] op;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op = 4'(i);
      exp_v = model(op, ra, rb);
      apply(op, ra, rb);
      check($sformatf("b2b_op%0d", i), exp_v[15:0], exp_v[16]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
